pran_test_sequencer: RTL and testbench

Synthesizable run-control sequencer that drives one test program on the PRAN RISC-V CPU without a simulator. It holds the CPU in reset and preloads a parametrised block of argument words, a zeroed result word and a zeroed done flag into data memory through the external write port. It then releases the CPU, snoops the CPU store bus for the result and done-flag writes, and reports pass, fail or timeout. It sits beside `pran_riscv_cpu` on the FPGA top level and drives its reset and `Ext_*` inputs.

---
 rtl/pran_test_sequencer.sv | 138 +++++++++++++
 tb/tb_pran_test_sequencer.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/pran_test_sequencer.sv
// pran_test_sequencer: preloads test arguments into CPU data memory, runs the CPU and reports pass/fail/timeout
module pran_test_sequencer #(
  parameter int NUM_ARGS = 3,
  parameter logic [31:0] BASE_ADDR = 32'h02000000,
  parameter int TIMEOUT_W = 20
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [32*NUM_ARGS-1:0]   arg_data,
  input  logic [31:0]              expected,
  input  logic                     MemWrite,
  input  logic [31:0]              WriteData,
  input  logic [31:0]              DataAdr,
  output logic                     cpu_reset,
  output logic                     Ext_MemWrite,
  output logic [31:0]              Ext_WriteData,
  output logic [31:0]              Ext_DataAdr,
  output logic                     busy,
  output logic                     done,
  output logic                     pass,
  output logic                     timeout,
  output logic [31:0]              result,
  output logic [TIMEOUT_W-1:0]     cycles
);
  typedef enum logic [2:0] {IDLE, LOAD, GAP, RUN, FINISH} state_t;
  localparam logic [31:0] RESULT_ADDR = BASE_ADDR + 32'(4*NUM_ARGS);
  localparam logic [31:0] DONE_ADDR = RESULT_ADDR + 32'd4;
  localparam int CW = $clog2(NUM_ARGS+2);
  localparam logic [CW-1:0] LAST = CW'(NUM_ARGS+1);
  localparam int SW = 32*(NUM_ARGS+2);
  state_t state, stateNext;
  logic [SW-1:0] shReg, shRegNext;
  logic [CW-1:0] loadCnt, loadCntNext;
  logic [31:0] expLatch, expNext;
  logic resultSeen, resultSeenNext;
  logic cpuResetNext, memWrNext, busyNext, doneNext, passNext, timeoutNext;
  logic [31:0] wrDataNext, wrAdrNext, resultNext;
  logic [TIMEOUT_W-1:0] cyclesNext, cyclesInc;
  logic accept, resultStore, doneStore, wdExpire;
  assign accept = (state == IDLE || state == FINISH) && start;
  assign resultStore = state == RUN && MemWrite && DataAdr == RESULT_ADDR;
  assign doneStore = state == RUN && MemWrite && DataAdr == DONE_ADDR && WriteData != '0;
  assign cyclesInc = cycles + TIMEOUT_W'(1);
  assign wdExpire = state == RUN && &cyclesInc;
  // state register
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else state <= stateNext;
  // next-state: load sequence, one gap cycle, run until done store or watchdog
  always_comb begin
    stateNext = state;
    case (state)
      IDLE, FINISH: stateNext = start ? LOAD : state;
      LOAD: stateNext = loadCnt == LAST ? GAP : LOAD;
      GAP: stateNext = RUN;
      RUN: stateNext = (doneStore || wdExpire) ? FINISH : RUN;
      default: stateNext = IDLE;
    endcase
  end
  // next output/datapath values; the argument words plus two zero words shift out one per load cycle
  always_comb begin
    shRegNext = shReg;
    loadCntNext = loadCnt;
    expNext = expLatch;
    resultSeenNext = resultSeen;
    memWrNext = 1'b0;
    wrDataNext = '0;
    wrAdrNext = '0;
    doneNext = done;
    passNext = pass;
    timeoutNext = timeout;
    resultNext = result;
    cyclesNext = cycles;
    if (accept) begin
      shRegNext = {64'b0, arg_data} >> 32;
      loadCntNext = '0;
      expNext = expected;
      resultSeenNext = 1'b0;
      memWrNext = 1'b1;
      wrDataNext = arg_data[31:0];
      wrAdrNext = BASE_ADDR;
      doneNext = 1'b0;
      passNext = 1'b0;
      timeoutNext = 1'b0;
      resultNext = '0;
      cyclesNext = '0;
    end else if (state == LOAD && loadCnt != LAST) begin
      shRegNext = shReg >> 32;
      loadCntNext = loadCnt + CW'(1);
      memWrNext = 1'b1;
      wrDataNext = shReg[31:0];
      wrAdrNext = Ext_DataAdr + 32'd4;
    end else if (state == RUN) begin
      cyclesNext = cyclesInc;
      resultNext = resultStore ? WriteData : result;
      resultSeenNext = resultSeen | resultStore;
      doneNext = doneStore | wdExpire;
      passNext = doneStore && resultSeen && result == expLatch;
      timeoutNext = !doneStore && wdExpire;
    end
    cpuResetNext = stateNext != RUN;
    busyNext = stateNext == LOAD || stateNext == GAP || stateNext == RUN;
  end
  // registered outputs and run context
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      shReg <= '0;
      loadCnt <= '0;
      expLatch <= '0;
      resultSeen <= 1'b0;
      cpu_reset <= 1'b1;
      Ext_MemWrite <= 1'b0;
      Ext_WriteData <= '0;
      Ext_DataAdr <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      pass <= 1'b0;
      timeout <= 1'b0;
      result <= '0;
      cycles <= '0;
    end else begin
      shReg <= shRegNext;
      loadCnt <= loadCntNext;
      expLatch <= expNext;
      resultSeen <= resultSeenNext;
      cpu_reset <= cpuResetNext;
      Ext_MemWrite <= memWrNext;
      Ext_WriteData <= wrDataNext;
      Ext_DataAdr <= wrAdrNext;
      busy <= busyNext;
      done <= doneNext;
      pass <= passNext;
      timeout <= timeoutNext;
      result <= resultNext;
      cycles <= cyclesNext;
    end
endmodule

// File: tb/tb_pran_test_sequencer.sv
// tb_pran_test_sequencer: randomized scoreboard bench for the run-control sequencer
module tb_pran_test_sequencer;
  localparam int N = 3;
  localparam int TW = 8;
  localparam logic [31:0] BASE = 32'h02000000;
  localparam logic [31:0] RES_A = BASE + 32'(4*N);
  localparam logic [31:0] DONE_A = RES_A + 32'd4;
  localparam int L = 300;
  localparam int LIMIT = (1 << TW) - 1;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0;
  logic [32*N-1:0] arg_data = '0;
  logic [31:0] expected = '0;
  logic MemWrite = 1'b0;
  logic [31:0] WriteData = '0;
  logic [31:0] DataAdr = '0;
  logic cpu_reset, Ext_MemWrite, busy, done, pass, timeout;
  logic [31:0] Ext_WriteData, Ext_DataAdr, result;
  logic [TW-1:0] cycles;
  pran_test_sequencer #(.NUM_ARGS(N), .BASE_ADDR(BASE), .TIMEOUT_W(TW)) dut (
    .clk(clk), .reset(reset), .start(start), .arg_data(arg_data), .expected(expected),
    .MemWrite(MemWrite), .WriteData(WriteData), .DataAdr(DataAdr),
    .cpu_reset(cpu_reset), .Ext_MemWrite(Ext_MemWrite), .Ext_WriteData(Ext_WriteData),
    .Ext_DataAdr(Ext_DataAdr), .busy(busy), .done(done), .pass(pass), .timeout(timeout),
    .result(result), .cycles(cycles)
  );
  always #5 clk = ~clk;
  typedef struct {logic [31:0] adr; logic [31:0] dat;} wr_t;
  typedef struct {logic pass; logic tmo; logic [31:0] res; logic [TW-1:0] cyc;} fin_t;
  wr_t wrQ[$];
  fin_t finQ[$];
  int nChecks = 0;
  int nFails = 0;
  logic opWe[L];
  logic [31:0] opAdr[L];
  logic [31:0] opDat[L];
  logic prevDone = 1'b0;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic checkIdle(input string tag);
    chk({tag, "_flags"}, 64'({cpu_reset, Ext_MemWrite, busy, done, pass, timeout}), 64'b100000);
    chk({tag, "_ext"}, {Ext_DataAdr, Ext_WriteData}, 64'd0);
    chk({tag, "_status"}, 64'({result, cycles}), 64'd0);
  endtask
  // reference: walk the CPU store stream cycle by cycle until a nonzero done store or the watchdog limit
  function automatic fin_t refRun(input logic [31:0] exp);
    fin_t f;
    logic seen;
    seen = 1'b0;
    f.res = '0;
    for (int j = 0; j < LIMIT; j++)
      if (opWe[j]) begin
        if (opAdr[j] == RES_A) begin
          f.res = opDat[j];
          seen = 1'b1;
        end else if (opAdr[j] == DONE_A && opDat[j] != 0) begin
          f.pass = seen && f.res == exp;
          f.tmo = 1'b0;
          f.cyc = TW'(j + 1);
          return f;
        end
      end
    f.pass = 1'b0;
    f.tmo = 1'b1;
    f.cyc = TW'(LIMIT);
    return f;
  endfunction
  task automatic clearOps();
    for (int j = 0; j < L; j++) begin
      opWe[j] = 1'b0;
      opAdr[j] = $urandom;
      opDat[j] = $urandom;
    end
  endtask
  task automatic setOp(input int j, input logic [31:0] adr, input logic [31:0] dat);
    opWe[j] = 1'b1;
    opAdr[j] = adr;
    opDat[j] = dat;
  endtask
  task automatic genOps(input logic noDone);
    int r;
    for (int j = 0; j < L; j++) begin
      opWe[j] = ($urandom % 3) == 0;
      r = $urandom % 8;
      if (r < 2) begin
        opAdr[j] = RES_A;
        opDat[j] = 32'd200 + ($urandom % 16);
      end else if (r == 2) begin
        opAdr[j] = DONE_A;
        opDat[j] = (!noDone && ($urandom % 4) == 0) ? ($urandom | 32'd1) : 32'd0;
      end else begin
        opAdr[j] = $urandom;
        if (opAdr[j] == RES_A || opAdr[j] == DONE_A) opAdr[j] = BASE;
        opDat[j] = $urandom;
      end
    end
  endtask
  function automatic logic [32*N-1:0] randArgs();
    logic [32*N-1:0] a;
    for (int i = 0; i < N; i++) a[32*i +: 32] = $urandom;
    return a;
  endfunction
  task automatic doRun(input logic [32*N-1:0] args, input logic [31:0] exp, input int startAt, input int abortAt);
    int cnt;
    int j;
    wr_t w;
    for (int i = 0; i < N + 2; i++) begin
      w.adr = BASE + 32'(4*i);
      w.dat = i < N ? args[32*i +: 32] : 32'd0;
      wrQ.push_back(w);
    end
    if (abortAt < 0) finQ.push_back(refRun(exp));
    @(negedge clk);
    arg_data = args;
    expected = exp;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    arg_data = randArgs();
    expected = ~exp;
    cnt = 0;
    while (cpu_reset && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    chk("cpu_reset_fall", 64'(cnt), 64'(N + 3));
    j = 0;
    while (!cpu_reset && j < L) begin
      if (j == abortAt) begin
        reset = 1'b0;
        #1;
        checkIdle("abort");
        @(negedge clk);
        reset = 1'b1;
        break;
      end
      MemWrite = opWe[j];
      DataAdr = opAdr[j];
      WriteData = opDat[j];
      start = j == startAt;
      @(negedge clk);
      j++;
    end
    MemWrite = 1'b0;
    DataAdr = '0;
    WriteData = '0;
    start = 1'b0;
    if (abortAt < 0) chk("run_finished", 64'(cpu_reset), 64'd1);
  endtask
  // monitor: every external write and every completion is matched against the scoreboard queues
  always @(negedge clk) begin : mon
    wr_t w;
    fin_t f;
    if (reset && Ext_MemWrite) begin
      if (wrQ.size() == 0) begin
        nChecks++;
        nFails++;
        $display("FAIL unexpected_write: got %h/%h expected none", Ext_DataAdr, Ext_WriteData);
      end else begin
        w = wrQ.pop_front();
        chk("load_write", {Ext_DataAdr, Ext_WriteData}, {w.adr, w.dat});
      end
    end
    if (reset && done && !prevDone) begin
      if (finQ.size() == 0) begin
        nChecks++;
        nFails++;
        $display("FAIL unexpected_done: got done=1 expected none");
      end else begin
        f = finQ.pop_front();
        chk("fin_pass", 64'(pass), 64'(f.pass));
        chk("fin_timeout", 64'(timeout), 64'(f.tmo));
        chk("fin_result", 64'(result), 64'(f.res));
        chk("fin_cycles", 64'(cycles), 64'(f.cyc));
        chk("fin_cpu_reset_busy", 64'({cpu_reset, busy}), 64'b10);
      end
    end
    prevDone = done;
  end
  initial begin
    clearOps();
    repeat (2) @(negedge clk);
    checkIdle("reset");
    reset = 1'b1;
    setOp(1, RES_A, 32'd210);
    setOp(3, DONE_A, 32'd1);
    doRun({32'd15, 32'd6, 32'd5}, 32'd210, -1, -1);
    clearOps();
    setOp(1, RES_A, 32'd209);
    setOp(3, DONE_A, 32'd1);
    doRun(randArgs(), 32'd210, -1, -1);
    clearOps();
    setOp(0, DONE_A, 32'd0);
    setOp(2, DONE_A, 32'd1);
    doRun(randArgs(), 32'd0, -1, -1);
    clearOps();
    doRun(randArgs(), 32'd210, -1, -1);
    clearOps();
    setOp(0, RES_A, 32'd7);
    setOp(LIMIT - 1, DONE_A, 32'd1);
    doRun(randArgs(), 32'd7, -1, -1);
    clearOps();
    setOp(1, RES_A, 32'd210);
    setOp(6, DONE_A, 32'd1);
    doRun(randArgs(), 32'd210, 2, -1);
    clearOps();
    setOp(1, RES_A, 32'd210);
    setOp(8, DONE_A, 32'd1);
    doRun(randArgs(), 32'd210, -1, 5);
    clearOps();
    setOp(1, RES_A, 32'd210);
    setOp(3, DONE_A, 32'd1);
    doRun({32'd15, 32'd6, 32'd5}, 32'd210, -1, -1);
    for (int k = 0; k < 20; k++) begin
      genOps(($urandom % 5) == 0);
      doRun(randArgs(), 32'd200 + ($urandom % 16), ($urandom % 2) ? int'($urandom_range(0, 20)) : -1, -1);
    end
    repeat (3) @(negedge clk);
    chk("write_queue_drained", 64'(wrQ.size()), 64'd0);
    chk("finish_queue_drained", 64'(finQ.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end
endmodule
